// File: rtl/vga_pkg.sv
// Shared timing constants, pixel type and colour-bar palette for the 1024x768@60 VGA path.
// The palette is only consumed when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 1024;
    localparam int VGA_H_FP     = 24;
    localparam int VGA_H_SYNC   = 136;
    localparam int VGA_H_BP     = 160;
    localparam int VGA_V_ACTIVE = 768;
    localparam int VGA_V_FP     = 3;
    localparam int VGA_V_SYNC   = 6;
    localparam int VGA_V_BP     = 29;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t BAR_WHITE   = 12'hFFF;
    localparam rgb444_t BAR_YELLOW  = 12'hFF0;
    localparam rgb444_t BAR_CYAN    = 12'h0FF;
    localparam rgb444_t BAR_GREEN   = 12'h0F0;
    localparam rgb444_t BAR_MAGENTA = 12'hF0F;
    localparam rgb444_t BAR_RED     = 12'hF00;
    localparam rgb444_t BAR_BLUE    = 12'h00F;
    localparam rgb444_t BAR_BLACK   = 12'h000;

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        rgb444_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// N-stage, W-bit shift register with asynchronous active-low clear to all-zero.
// Used to align raster control bits with frame-buffer read data.
module vga_delay_line #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_timing_fetch.sv
// Raster timing, frame-buffer fetch and latency-aligned output stage for 1024x768@60.
// Define VGA_TEST_PATTERN_EN to replace rd_data with eight vertical colour bars.
module vga_timing_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int SCALE    = 2,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              cpu_resetn,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic              hs,
    output logic              vs,
    output logic              frame_start,
    output logic [11:0]       vga_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DLY     = RD_LAT + 1;

    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT     = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    HS_START  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT     = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    VS_START  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0]    ROW_MASK  = V_W'((1 << SCALE) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE);

    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    logic              frame_start_q, frame_start_d;
    rgb444_t           vga_data_q, vga_data_d;
    rgb444_t           pix;
    logic              de0, hs0, vs0, fs0;
    logic              de_dl, hs_dl, vs_dl, fs_dl;

    // Line base tracks (v_cnt>>SCALE)*(H_ACTIVE>>SCALE) so no multiplier is needed.
    always_comb begin
        h_cnt_d     = h_cnt_q + 1'b1;
        v_cnt_d     = v_cnt_q;
        line_base_d = line_base_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d     = '0;
                line_base_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
                if ((v_cnt_d & ROW_MASK) == '0) begin
                    line_base_d = line_base_q + LINE_STEP;
                end
            end
        end
    end

    assign de0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs0 = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs0 = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign fs0 = (h_cnt_q == '0) && (v_cnt_q == '0);

    always_comb begin
        rd_en_d   = de0;
        rd_addr_d = rd_addr_q;
        if (de0) begin
            rd_addr_d = line_base_q + ADDR_W'(h_cnt_q >> SCALE);
        end
    end

    // Control bits are carried active-high; polarity is applied at the pins.
    vga_delay_line #(.N(DLY), .W(4)) u_ctrl_dly (
        .clk   (clk),
        .rst_n (cpu_resetn),
        .din   ({de0, hs0, vs0, fs0}),
        .dout  ({de_dl, hs_dl, vs_dl, fs_dl})
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [10:0] x0;
    logic [2:0]  x_dl;
    assign x0 = 11'(h_cnt_q);
    vga_delay_line #(.N(DLY), .W(3)) u_x_dly (
        .clk   (clk),
        .rst_n (cpu_resetn),
        .din   (x0[9:7]),
        .dout  (x_dl)
    );
    assign pix = bar_colour(x_dl);
`else
    assign pix = rd_data;
`endif

    always_comb begin
        vga_data_d    = de_dl ? pix : 12'h000;
        hs_d          = hs_dl ^ ~SYNC_POL;
        vs_d          = vs_dl ^ ~SYNC_POL;
        frame_start_d = fs_dl;
    end

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_base_q   <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            frame_start_q <= 1'b0;
            vga_data_q    <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_base_q   <= line_base_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            vga_data_q    <= vga_data_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = frame_start_q;
    assign vga_data    = vga_data_q;

endmodule

// File: tb/tb_vga_timing_fetch.sv
// Bench for vga_timing_fetch: a reduced-raster instance scored cycle by cycle against a
// reference model, plus a full 1024x768 instance checked at its first-line landmarks.
module tb_vga_timing_fetch;

    localparam int SH_ACT = 64, SH_FP = 4, SH_SYNC = 8, SH_BP = 12;
    localparam int SV_ACT = 16, SV_FP = 2, SV_SYNC = 3, SV_BP = 4;
    localparam int SH_TOT = SH_ACT + SH_FP + SH_SYNC + SH_BP;
    localparam int SV_TOT = SV_ACT + SV_FP + SV_SYNC + SV_BP;
    localparam int FRAME  = SH_TOT * SV_TOT;
    localparam int LAT    = 3;
    localparam logic [14:0] RST_OUT = {1'b1, 1'b1, 1'b0, 12'h000};

    logic        clk = 1'b0;
    logic        cpu_resetn;
    always #5 clk = ~clk;

    logic        s_rd_en, s_hs, s_vs, s_fs;
    logic [15:0] s_rd_addr;
    logic [11:0] s_rd_data, s_vga;
    logic        f_rd_en, f_hs, f_vs, f_fs;
    logic [15:0] f_rd_addr;
    logic [11:0] f_rd_data, f_vga;

    vga_timing_fetch #(
        .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut (
        .clk(clk), .cpu_resetn(cpu_resetn), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .vga_data(s_vga)
    );

    vga_timing_fetch dut_full (
        .clk(clk), .cpu_resetn(cpu_resetn), .rd_en(f_rd_en), .rd_addr(f_rd_addr),
        .rd_data(f_rd_data), .hs(f_hs), .vs(f_vs), .frame_start(f_fs), .vga_data(f_vga)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] pat(input logic [15:0] a);
        logic [31:0] t;
        t = a * 32'd37 + 32'h5A3;
        return t[11:0];
    endfunction

    function automatic logic [15:0] model_addr(input int h, input int v);
        return 16'((v / 4) * (SH_ACT / 4) + h / 4);
    endfunction

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] bar_tbl [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    function automatic logic [14:0] model_out(input int h, input int v, input logic fff);
        logic de, hsa, vsa, fs;
        logic [11:0] d;
        de  = (h < SH_ACT) && (v < SV_ACT);
        hsa = (h >= SH_ACT + SH_FP) && (h < SH_ACT + SH_FP + SH_SYNC);
        vsa = (v >= SV_ACT + SV_FP) && (v < SV_ACT + SV_FP + SV_SYNC);
        fs  = (h == 0) && (v == 0);
        d   = 12'h000;
        if (de) d = fff ? 12'hFFF : pat(model_addr(h, v));
`ifdef VGA_TEST_PATTERN_EN
        if (de) d = bar_tbl[(h >> 7) & 7];
`endif
        return {~hsa, ~vsa, fs, d};
    endfunction

    // Frame-buffer model with one clock of read latency.
    logic bram_fff;
    always @(posedge clk) s_rd_data <= bram_fff ? 12'hFFF : pat(s_rd_addr);

    logic [14:0] exp_q[$];
    logic [14:0] e_out;
    int          m_h, m_v, n, fs_last;
    logic        m_rd_en;
    logic [15:0] m_rd_addr;
    logic        f_hs_prev;
    int          f_fall1 = -1, f_fall2 = -1, f_rise1 = -1;

    always @(negedge clk) begin
        if (!cpu_resetn) begin
            check("rst_hs", s_hs, 1);
            check("rst_vs", s_vs, 1);
            check("rst_fs", s_fs, 0);
            check("rst_vga", s_vga, 0);
            check("rst_rd_en", s_rd_en, 0);
            check("rst_rd_addr", s_rd_addr, 0);
            check("rst_full_hs", f_hs, 1);
            check("rst_full_vs", f_vs, 1);
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(RST_OUT);
            m_h = 0; m_v = 0; n = 0; fs_last = -1;
            m_rd_en = 1'b0; m_rd_addr = '0; f_hs_prev = 1'b1;
        end else begin
            check("rd_en", s_rd_en, m_rd_en);
            check("rd_addr", s_rd_addr, m_rd_addr);
            e_out = exp_q.pop_front();
            check("hs", s_hs, e_out[14]);
            check("vs", s_vs, e_out[13]);
            check("frame_start", s_fs, e_out[12]);
            check("vga_data", s_vga, e_out[11:0]);
            exp_q.push_back(model_out(m_h, m_v, bram_fff));
            if (m_h < SH_ACT && m_v < SV_ACT) begin
                m_rd_en = 1'b1;
                m_rd_addr = model_addr(m_h, m_v);
            end else begin
                m_rd_en = 1'b0;
            end
            m_h++;
            if (m_h == SH_TOT) begin
                m_h = 0;
                m_v++;
                if (m_v == SV_TOT) m_v = 0;
            end
            if (s_fs) begin
                if (fs_last >= 0) check("fs_period", n - fs_last, FRAME);
                fs_last = n;
            end
            // n = clock edges since reset release; full-raster landmarks.
            if (n >= 1 && n <= 1344) check("full_rd_en", f_rd_en, (n <= 1024) ? 1 : 0);
            if (n == 5381) check("full_rd_addr_4_4", f_rd_addr, 257);
            if (f_hs_prev && !f_hs) begin
                if (f_fall1 < 0) f_fall1 = n;
                else if (f_fall2 < 0) f_fall2 = n;
            end
            if (!f_hs_prev && f_hs && f_rise1 < 0) f_rise1 = n;
            f_hs_prev = f_hs;
            n++;
        end
    end

    task automatic mid_reset(input int v, input int h, input logic fff);
        int waited;
        int got;
        waited = 0;
        while (!(m_v == v && m_h == h) && waited < 2 * FRAME) begin
            @(posedge clk);
            waited++;
        end
        check("mid_reset_position", (waited < 2 * FRAME) ? 1 : 0, 1);
        #2 cpu_resetn = 1'b0;
        #1;
        check("async_hs", s_hs, 1);
        check("async_vs", s_vs, 1);
        check("async_vga", s_vga, 0);
        check("async_fs", s_fs, 0);
        check("async_rd_en", s_rd_en, 0);
        check("async_rd_addr", s_rd_addr, 0);
        bram_fff = fff;
        repeat (3) @(posedge clk);
        #1 cpu_resetn = 1'b1;
        got = -1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            #1;
            if (s_fs && got < 0) got = e;
        end
        check("fs_after_release", got, LAT);
    endtask

    initial begin
        cpu_resetn = 1'b0;
        bram_fff   = 1'b0;
        f_rd_data  = 12'h000;
        repeat (4) @(posedge clk);
        #1 cpu_resetn = 1'b1;
        repeat (3 * FRAME) @(posedge clk);
        check("full_hs_first_fall", f_fall1, 1051);
        check("full_hs_low_width", f_rise1 - f_fall1, 136);
        check("full_hs_period", f_fall2 - f_fall1, 1344);
        mid_reset(10, 20, 1'b1);
        repeat (FRAME + 300) @(posedge clk);
        mid_reset(19, 74, 1'b0);
        repeat (FRAME + 300) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
